// File: rtl/i2c_master_burst_ctrl.sv
// i2c_master_burst_ctrl: multi-byte I2C transaction sequencer on top of the
// bit controller. One go request runs START, address/RW, LEN data bytes and
// then STOP or a held bus. TX/RX FIFOs decouple the host from the bus.
module i2c_master_burst_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    go,
  input  logic                    rw,
  input  logic [6:0]              slv_addr,
  input  logic [CNT_W-1:0]        len,
  input  logic                    stop_en,
  input  logic                    tx_push,
  input  logic [7:0]              tx_data,
  output logic                    tx_full,
  output logic [$clog2(DEPTH):0]  tx_level,
  input  logic                    rx_pop,
  output logic [7:0]              rx_data,
  output logic                    rx_empty,
  output logic [$clog2(DEPTH):0]  rx_level,
  output logic                    busy,
  output logic                    done,
  output logic                    nack_err,
  output logic                    al_err,
  output logic [3:0]              core_cmd,
  output logic                    core_txd,
  input  logic                    core_ack,
  input  logic                    core_rxd,
  input  logic                    core_al,
  output logic [3:0]              dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [3:0] CMD_NOP = 4'b0000, CMD_START = 4'b0001, CMD_STOP = 4'b0010,
                         CMD_WRITE = 4'b0100, CMD_READ = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_ADDR_ACK, ST_WR, ST_WR_ACK,
    ST_RD, ST_RD_ACK, ST_STOP, ST_HOLD
  } state_t;

  // Handshake with the bit controller: core_cmd is the request and is held
  // stable until the single-cycle core_ack completes it; the following
  // command (or NOP while waiting for FIFO data/space) is registered on the
  // ack edge. core_al aborts any pending request and wins over core_ack.

  state_t            state, state_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [7:0]        sr, sr_d;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_d;
  logic              loaded, loaded_d;
  logic              rw_q, rw_d, stop_q, stop_d, nack_d, al_d;
  logic              busy_d, done_d, txd_d;
  logic [3:0]        cmd_d;
  logic              tx_pop_int, rx_push_int;
  logic [7:0]        rx_wdata;

  // TX FIFO
  logic [7:0]     tx_mem [DEPTH];
  logic [AW-1:0]  tx_wp, tx_rp;
  logic [AW:0]    tx_cnt;
  logic           tx_empty, tx_wr_en, tx_rd_en;
  logic [7:0]     tx_head;
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_LVL);
  assign tx_wr_en = tx_push && !tx_full;
  assign tx_rd_en = tx_pop_int && !tx_empty;
  assign tx_level = tx_cnt;
  assign tx_head  = tx_mem[tx_rp];

  // RX FIFO
  logic [7:0]     rx_mem [DEPTH];
  logic [AW-1:0]  rx_wp, rx_rp;
  logic [AW:0]    rx_cnt;
  logic           rx_full, rx_wr_en, rx_rd_en;
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_LVL);
  assign rx_wr_en = rx_push_int && !rx_full;
  assign rx_rd_en = rx_pop && !rx_empty;
  assign rx_level = rx_cnt;
  assign rx_data  = rx_mem[rx_rp];
  assign rx_wdata = {sr[6:0], core_rxd};

  assign dbg_state = state;

  // FIFO storage writes (no reset needed on the data array)
  always_ff @(posedge clk) begin
    if (tx_wr_en) tx_mem[tx_wp] <= tx_data;
    if (rx_wr_en) rx_mem[rx_wp] <= rx_wdata;
  end

  // FIFO pointers and occupancy counters
  always_ff @(posedge clk) begin
    if (!nReset) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_wr_en) tx_wp <= tx_wp + 1'b1;
      if (tx_rd_en) tx_rp <= tx_rp + 1'b1;
      if (tx_wr_en && !tx_rd_en) tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_wr_en && tx_rd_en) tx_cnt <= tx_cnt - 1'b1;
      if (rx_wr_en) rx_wp <= rx_wp + 1'b1;
      if (rx_rd_en) rx_rp <= rx_rp + 1'b1;
      if (rx_wr_en && !rx_rd_en) rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_wr_en && rx_rd_en) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  // State register plus sequencer datapath and registered bus command
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= ST_IDLE; bit_cnt <= '0; sr <= '0; byte_cnt <= '0; loaded <= 1'b0;
      rw_q <= 1'b0; stop_q <= 1'b0; nack_err <= 1'b0; al_err <= 1'b0;
      busy <= 1'b0; done <= 1'b0; core_cmd <= CMD_NOP; core_txd <= 1'b0;
    end else begin
      state <= state_d; bit_cnt <= bit_cnt_d; sr <= sr_d; byte_cnt <= byte_cnt_d;
      loaded <= loaded_d; rw_q <= rw_d; stop_q <= stop_d;
      nack_err <= nack_d; al_err <= al_d;
      busy <= busy_d; done <= done_d; core_cmd <= cmd_d; core_txd <= txd_d;
    end
  end

  // Next-state and datapath: sequencing on core_ack, byte start on FIFO state
  always_comb begin
    state_d = state; bit_cnt_d = bit_cnt; sr_d = sr; byte_cnt_d = byte_cnt;
    loaded_d = loaded; rw_d = rw_q; stop_d = stop_q; nack_d = nack_err; al_d = al_err;
    tx_pop_int = 1'b0; rx_push_int = 1'b0;
    if (core_al) begin
      state_d = ST_IDLE; al_d = 1'b1; loaded_d = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: if (go) begin
          state_d = ST_START; rw_d = rw; stop_d = stop_en; byte_cnt_d = len;
          sr_d = {slv_addr, rw}; nack_d = 1'b0; al_d = 1'b0; bit_cnt_d = '0; loaded_d = 1'b0;
        end
        ST_START: if (core_ack) state_d = ST_ADDR;
        ST_ADDR: if (core_ack) begin
          sr_d = {sr[6:0], 1'b0}; bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = ST_ADDR_ACK;
        end
        ST_ADDR_ACK: if (core_ack) begin
          if (core_rxd) begin nack_d = 1'b1; state_d = ST_STOP; end
          else if (byte_cnt == '0) state_d = stop_q ? ST_STOP : ST_HOLD;
          else state_d = rw_q ? ST_RD : ST_WR;
        end
        ST_WR: if (loaded && core_ack) begin
          sr_d = {sr[6:0], 1'b0}; bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin state_d = ST_WR_ACK; loaded_d = 1'b0; end
        end
        ST_WR_ACK: if (core_ack) begin
          if (core_rxd) begin nack_d = 1'b1; state_d = ST_STOP; end
          else begin
            byte_cnt_d = byte_cnt - 1'b1;
            if (byte_cnt == CNT_ONE) state_d = stop_q ? ST_STOP : ST_HOLD;
            else state_d = ST_WR;
          end
        end
        ST_RD: if (loaded && core_ack) begin
          sr_d = rx_wdata; bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin rx_push_int = 1'b1; state_d = ST_RD_ACK; loaded_d = 1'b0; end
        end
        ST_RD_ACK: if (core_ack) begin
          byte_cnt_d = byte_cnt - 1'b1;
          if (byte_cnt == CNT_ONE) state_d = stop_q ? ST_STOP : ST_HOLD;
          else state_d = ST_RD;
        end
        ST_STOP: if (core_ack) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      // A data byte starts only once the TX head exists / RX has room.
      if (state_d == ST_WR && !loaded_d && !tx_empty) begin
        tx_pop_int = 1'b1; sr_d = tx_head; loaded_d = 1'b1; bit_cnt_d = '0;
      end
      if (state_d == ST_RD && !loaded_d && !rx_full) begin
        loaded_d = 1'b1; bit_cnt_d = '0;
      end
    end
  end

  // Output decode: command for the upcoming state, busy and done pulse
  always_comb begin
    cmd_d = CMD_NOP; txd_d = 1'b0;
    case (state_d)
      ST_START:               cmd_d = CMD_START;
      ST_ADDR:                begin cmd_d = CMD_WRITE; txd_d = sr_d[7]; end
      ST_ADDR_ACK, ST_WR_ACK: begin cmd_d = CMD_READ; txd_d = 1'b1; end
      ST_WR:                  if (loaded_d) begin cmd_d = CMD_WRITE; txd_d = sr_d[7]; end
      ST_RD:                  if (loaded_d) cmd_d = CMD_READ;
      ST_RD_ACK:              begin cmd_d = CMD_WRITE; txd_d = (byte_cnt_d == CNT_ONE); end
      ST_STOP:                cmd_d = CMD_STOP;
      default:                cmd_d = CMD_NOP;
    endcase
    busy_d = !(state_d == ST_IDLE || state_d == ST_HOLD);
    done_d = core_al || (busy && !busy_d);
  end

endmodule
